// File: rtl/pipe_pkg.sv
// Shared encodings for the pipeline control block: FSM states, pc_sel and push_sel codes,
// and default widths.
package pipe_pkg;

  localparam int PC_W_DEF    = 32;
  localparam int CAUSE_W_DEF = 4;
  localparam int REG_AW_DEF  = 3;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_DRAIN    = 3'd1,
    ST_PUSH_PCH = 3'd2,
    ST_PUSH_PCL = 3'd3,
    ST_PUSH_FLG = 3'd4,
    ST_VECTOR   = 3'd5
  } ctrl_state_t;

  localparam logic [1:0] PCSEL_SEQ = 2'b00;
  localparam logic [1:0] PCSEL_INT = 2'b01;
  localparam logic [1:0] PCSEL_EXC = 2'b10;

  localparam logic [1:0] PUSH_PCH = 2'b00;
  localparam logic [1:0] PUSH_PCL = 2'b01;
  localparam logic [1:0] PUSH_FLG = 2'b10;

endpackage

// File: rtl/pipeline_ctrl_hazard_detect.sv
// Load-use comparator: flags an IF_ID instruction that reads the destination of a load
// still sitting in ID_EX.
module hazard_detect #(
  parameter int REG_AW = 3
) (
  input  logic              i_idex_mem_read,
  input  logic [REG_AW-1:0] i_idex_rdst,
  input  logic [REG_AW-1:0] i_ifid_rsrc,
  input  logic [REG_AW-1:0] i_ifid_rdst,
  input  logic              i_ifid_use_src,
  input  logic              i_ifid_use_dst,
  output logic              o_load_use
);

  logic w_src_hit;
  logic w_dst_hit;

  assign w_src_hit  = i_ifid_use_src && (i_ifid_rsrc == i_idex_rdst);
  assign w_dst_hit  = i_ifid_use_dst && (i_ifid_rdst == i_idex_rdst);
  assign o_load_use = i_idex_mem_read && (w_src_hit || w_dst_hit);

endmodule

// File: rtl/pipeline_ctrl.sv
// Hazard and control-flow sequencer: load-use stalls, jump flushes, exception redirect and
// the multi-cycle interrupt entry. Define PIPECTRL_INT_EDGE_EN for edge-triggered interrupts.
module pipeline_ctrl
  import pipe_pkg::*;
#(
  parameter int PC_W         = PC_W_DEF,
  parameter int REG_AW       = REG_AW_DEF,
  parameter int CAUSE_W      = CAUSE_W_DEF,
  parameter int DRAIN_CYCLES = 3
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               interrupt,
  input  logic               int_en,
  input  logic               exception_in,
  input  logic [CAUSE_W-1:0] cause_in,
  input  logic [PC_W-1:0]    exc_pc_in,
  input  logic               jmp_taken,
  input  logic               idex_mem_read,
  input  logic [REG_AW-1:0]  idex_rdst,
  input  logic [REG_AW-1:0]  ifid_rsrc,
  input  logic [REG_AW-1:0]  ifid_rdst,
  input  logic               ifid_use_src,
  input  logic               ifid_use_dst,
  input  logic               push_ack,
  input  logic [PC_W-1:0]    int_pc,
  output logic               stall,
  output logic               flush_if_id,
  output logic               flush_id_ex,
  output logic               flush_ex_mem,
  output logic [1:0]         pc_sel,
  output logic               push_req,
  output logic [1:0]         push_sel,
  output logic [PC_W-1:0]    push_pc,
  output logic               clr_int,
  output logic [PC_W-1:0]    EPC,
  output logic [CAUSE_W-1:0] CAUSE
);

  localparam logic [3:0] DRAIN_LAST = 4'(DRAIN_CYCLES - 1);

  ctrl_state_t        r_state;
  ctrl_state_t        w_next;
  logic               r_pending;
  logic [3:0]         r_cnt;
  logic [PC_W-1:0]    r_push_pc;
  logic [PC_W-1:0]    r_epc;
  logic [CAUSE_W-1:0] r_cause;
  logic               w_load_use;
  logic               w_go;
  logic               w_int_set;

  hazard_detect #(.REG_AW(REG_AW)) u_hazard (
    .i_idex_mem_read (idex_mem_read),
    .i_idex_rdst     (idex_rdst),
    .i_ifid_rsrc     (ifid_rsrc),
    .i_ifid_rdst     (ifid_rdst),
    .i_ifid_use_src  (ifid_use_src),
    .i_ifid_use_dst  (ifid_use_dst),
    .o_load_use      (w_load_use)
  );

`ifdef PIPECTRL_INT_EDGE_EN
  logic r_int_prev;

  always_ff @(posedge clk) begin
    if (!reset) r_int_prev <= 1'b0;
    else        r_int_prev <= interrupt;
  end

  assign w_int_set = interrupt && !r_int_prev;
`else
  assign w_int_set = interrupt;
`endif

  // NOTE: every output gets a default before the case so no path leaves one unassigned
  // and infers a latch.
  always_comb begin
    w_next       = r_state;
    w_go         = 1'b0;
    stall        = 1'b0;
    flush_if_id  = 1'b0;
    flush_id_ex  = 1'b0;
    flush_ex_mem = 1'b0;
    pc_sel       = PCSEL_SEQ;
    push_req     = 1'b0;
    push_sel     = PUSH_PCH;
    clr_int      = 1'b0;

    if (exception_in) begin
      flush_if_id  = 1'b1;
      flush_id_ex  = 1'b1;
      flush_ex_mem = 1'b1;
      pc_sel       = PCSEL_EXC;
      w_next       = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: begin
          // A resolved jump discards the stalled instruction anyway, so it wins over load-use.
          if (jmp_taken) begin
            flush_if_id = 1'b1;
            flush_id_ex = 1'b1;
          end else if (w_load_use) begin
            stall       = 1'b1;
            flush_id_ex = 1'b1;
          end
          if (r_pending && int_en && !jmp_taken) begin
            w_go   = 1'b1;
            w_next = ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          stall       = 1'b1;
          flush_if_id = 1'b1;
          clr_int     = (r_cnt == 4'd0);
          if (r_cnt == DRAIN_LAST) w_next = ST_PUSH_PCH;
        end
        ST_PUSH_PCH: begin
          stall    = 1'b1;
          push_req = 1'b1;
          push_sel = PUSH_PCH;
          if (push_ack) w_next = ST_PUSH_PCL;
        end
        ST_PUSH_PCL: begin
          stall    = 1'b1;
          push_req = 1'b1;
          push_sel = PUSH_PCL;
          if (push_ack) w_next = ST_PUSH_FLG;
        end
        ST_PUSH_FLG: begin
          stall    = 1'b1;
          push_req = 1'b1;
          push_sel = PUSH_FLG;
          if (push_ack) w_next = ST_VECTOR;
        end
        ST_VECTOR: begin
          pc_sel      = PCSEL_INT;
          flush_if_id = 1'b1;
          w_next      = ST_IDLE;
        end
        default: w_next = ST_IDLE;
      endcase
    end
  end

  // NOTE: state registers use non-blocking assignments so every register samples the
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state   <= ST_IDLE;
      r_pending <= 1'b0;
      r_cnt     <= 4'd0;
      r_push_pc <= '0;
      r_epc     <= '0;
      r_cause   <= '0;
    end else begin
      r_state <= w_next;

      if (exception_in) begin
        r_epc   <= exc_pc_in;
        r_cause <= cause_in;
        r_cnt   <= 4'd0;
      end else if (r_state == ST_DRAIN) begin
        r_cnt <= (r_cnt == DRAIN_LAST) ? 4'd0 : r_cnt + 4'd1;
      end

      if (w_go) r_push_pc <= int_pc;

      // An abandoned entry must be retried, so its request goes back to pending.
      if (exception_in)
        r_pending <= r_pending || w_int_set || (r_state != ST_IDLE);
      else if (w_go)
        r_pending <= w_int_set;
      else
        r_pending <= r_pending || w_int_set;
    end
  end

  assign push_pc = r_push_pc;
  assign EPC     = r_epc;
  assign CAUSE   = r_cause;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed bench for pipeline_ctrl: inputs change 1 time unit after each rising edge and
// outputs are sampled 1 unit later, well clear of the next edge.
module tb_pipeline_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        interrupt;
  logic        int_en;
  logic        exception_in;
  logic [3:0]  cause_in;
  logic [31:0] exc_pc_in;
  logic        jmp_taken;
  logic        idex_mem_read;
  logic [2:0]  idex_rdst;
  logic [2:0]  ifid_rsrc;
  logic [2:0]  ifid_rdst;
  logic        ifid_use_src;
  logic        ifid_use_dst;
  logic        push_ack;
  logic [31:0] int_pc;
  logic        stall;
  logic        flush_if_id;
  logic        flush_id_ex;
  logic        flush_ex_mem;
  logic [1:0]  pc_sel;
  logic        push_req;
  logic [1:0]  push_sel;
  logic [31:0] push_pc;
  logic        clr_int;
  logic [31:0] EPC;
  logic [3:0]  CAUSE;

  int n_pass  = 0;
  int n_total = 0;

  logic [9:0] w_ctl;
  logic [9:0] C_IDLE, C_LU, C_JMP, C_DRAIN0, C_DRAIN, C_PCH, C_PCL, C_FLG, C_VEC, C_EXC;

  pipeline_ctrl #(.PC_W(32), .REG_AW(3), .CAUSE_W(4), .DRAIN_CYCLES(3)) dut (
    .clk           (clk),
    .reset         (reset),
    .interrupt     (interrupt),
    .int_en        (int_en),
    .exception_in  (exception_in),
    .cause_in      (cause_in),
    .exc_pc_in     (exc_pc_in),
    .jmp_taken     (jmp_taken),
    .idex_mem_read (idex_mem_read),
    .idex_rdst     (idex_rdst),
    .ifid_rsrc     (ifid_rsrc),
    .ifid_rdst     (ifid_rdst),
    .ifid_use_src  (ifid_use_src),
    .ifid_use_dst  (ifid_use_dst),
    .push_ack      (push_ack),
    .int_pc        (int_pc),
    .stall         (stall),
    .flush_if_id   (flush_if_id),
    .flush_id_ex   (flush_id_ex),
    .flush_ex_mem  (flush_ex_mem),
    .pc_sel        (pc_sel),
    .push_req      (push_req),
    .push_sel      (push_sel),
    .push_pc       (push_pc),
    .clr_int       (clr_int),
    .EPC           (EPC),
    .CAUSE         (CAUSE)
  );

  always #5 clk = ~clk;

  assign w_ctl = {stall, flush_if_id, flush_id_ex, flush_ex_mem, pc_sel, push_req, push_sel, clr_int};

  function automatic logic [9:0] ctl(input logic st, input logic fi, input logic fd,
                                     input logic fe, input logic [1:0] pc, input logic pr,
                                     input logic [1:0] ps, input logic ci);
    return {st, fi, fd, fe, pc, pr, ps, ci};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  // Walks a full entry from the first DRAIN cycle through the return to IDLE (ack high).
  task automatic expect_entry(input string tag);
    logic [9:0] seq [8];
    seq = '{C_DRAIN0, C_DRAIN, C_DRAIN, C_PCH, C_PCL, C_FLG, C_VEC, C_IDLE};
    for (int i = 0; i < 8; i++) begin
      tick();
      settle();
      check($sformatf("%s_c%0d", tag, i + 1), 32'(w_ctl), 32'(seq[i]));
    end
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int clr_count;

    C_IDLE   = '0;
    C_LU     = ctl(1, 0, 1, 0, 2'b00, 0, 2'b00, 0);
    C_JMP    = ctl(0, 1, 1, 0, 2'b00, 0, 2'b00, 0);
    C_DRAIN0 = ctl(1, 1, 0, 0, 2'b00, 0, 2'b00, 1);
    C_DRAIN  = ctl(1, 1, 0, 0, 2'b00, 0, 2'b00, 0);
    C_PCH    = ctl(1, 0, 0, 0, 2'b00, 1, 2'b00, 0);
    C_PCL    = ctl(1, 0, 0, 0, 2'b00, 1, 2'b01, 0);
    C_FLG    = ctl(1, 0, 0, 0, 2'b00, 1, 2'b10, 0);
    C_VEC    = ctl(0, 1, 0, 0, 2'b01, 0, 2'b00, 0);
    C_EXC    = ctl(0, 1, 1, 1, 2'b10, 0, 2'b00, 0);

    reset = 1'b0; interrupt = 1'b0; int_en = 1'b0; exception_in = 1'b0;
    cause_in = '0; exc_pc_in = '0; jmp_taken = 1'b0; idex_mem_read = 1'b0;
    idex_rdst = '0; ifid_rsrc = '0; ifid_rdst = '0; ifid_use_src = 1'b0;
    ifid_use_dst = 1'b0; push_ack = 1'b0; int_pc = '0;

    tick(); tick();
    settle();
    check("rst_ctl",     32'(w_ctl), 32'(C_IDLE));
    check("rst_epc",     EPC,        32'h0);
    check("rst_cause",   32'(CAUSE), 32'h0);
    check("rst_push_pc", push_pc,    32'h0);
    reset = 1'b1;

    // Load-use hazard patterns.
    tick();
    idex_mem_read = 1'b1; idex_rdst = 3'd3; ifid_rsrc = 3'd3; ifid_use_src = 1'b1;
    settle(); check("lu_src_hit", 32'(w_ctl), 32'(C_LU));
    ifid_rsrc = 3'd4;
    settle(); check("lu_src_miss", 32'(w_ctl), 32'(C_IDLE));
    ifid_use_src = 1'b0; ifid_use_dst = 1'b1; ifid_rdst = 3'd3;
    settle(); check("lu_dst_hit", 32'(w_ctl), 32'(C_LU));
    idex_mem_read = 1'b0;
    settle(); check("lu_no_load", 32'(w_ctl), 32'(C_IDLE));
    idex_mem_read = 1'b1; ifid_use_dst = 1'b0; ifid_use_src = 1'b1; ifid_rsrc = 3'd3;
    ifid_rdst = 3'd3;
    settle(); check("lu_unused_ops", 32'(w_ctl), 32'(C_LU));
    jmp_taken = 1'b1;
    settle(); check("jmp_over_lu", 32'(w_ctl), 32'(C_JMP));
    tick();
    jmp_taken = 1'b0; idex_mem_read = 1'b0; ifid_use_src = 1'b0;
    settle(); check("quiet", 32'(w_ctl), 32'(C_IDLE));

    // Interrupt entry with ack tied high.
    interrupt = 1'b1; int_en = 1'b1; push_ack = 1'b1; int_pc = 32'h0000_1234;
    settle(); check("int_req_cycle", 32'(w_ctl), 32'(C_IDLE));
    tick();
    interrupt = 1'b0;
    settle(); check("int_go_cycle", 32'(w_ctl), 32'(C_IDLE));
    expect_entry("entry");
    check("entry_push_pc", push_pc, 32'h0000_1234);
    tick(); settle(); check("entry_stays_idle", 32'(w_ctl), 32'(C_IDLE));

    // Backpressure in PUSH_PCL.
    interrupt = 1'b1; int_pc = 32'h0000_5678;
    tick(); interrupt = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    settle(); check("bp_pch", 32'(w_ctl), 32'(C_PCH));
    tick(); push_ack = 1'b0;
    for (int i = 0; i < 5; i++) begin
      settle(); check($sformatf("bp_hold%0d", i), 32'(w_ctl), 32'(C_PCL));
      tick();
    end
    push_ack = 1'b1;
    settle(); check("bp_ack_cycle", 32'(w_ctl), 32'(C_PCL));
    tick(); settle(); check("bp_flg", 32'(w_ctl), 32'(C_FLG));
    tick(); settle(); check("bp_vec", 32'(w_ctl), 32'(C_VEC));
    check("bp_push_pc", push_pc, 32'h0000_5678);
    tick(); settle(); check("bp_idle", 32'(w_ctl), 32'(C_IDLE));

    // Exception during PUSH_PCH abandons the entry and re-arms pending.
    interrupt = 1'b1; int_pc = 32'h0000_1234;
    tick(); interrupt = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    settle(); check("exc_pre_pch", 32'(w_ctl), 32'(C_PCH));
    exception_in = 1'b1; cause_in = 4'h2; exc_pc_in = 32'h0000_00A0;
    settle(); check("exc_outputs", 32'(w_ctl), 32'(C_EXC));
    tick();
    exception_in = 1'b0; cause_in = '0; exc_pc_in = '0;
    settle();
    check("exc_epc",   EPC,        32'h0000_00A0);
    check("exc_cause", 32'(CAUSE), 32'h2);
    check("exc_idle",  32'(w_ctl), 32'(C_IDLE));
    tick(); settle(); check("exc_reentry", 32'(w_ctl), 32'(C_DRAIN0));

    // Synchronous reset in DRAIN.
    tick();
    reset = 1'b0;
    tick(); settle();
    check("rst_mid_ctl",     32'(w_ctl), 32'(C_IDLE));
    check("rst_mid_epc",     EPC,        32'h0);
    check("rst_mid_push_pc", push_pc,    32'h0);
    reset = 1'b1;
    tick(); tick(); settle();
    check("rst_mid_no_pending", 32'(w_ctl), 32'(C_IDLE));

    // Request parked while int_en is low, serviced once it rises.
    int_en = 1'b0; interrupt = 1'b1;
    tick(); interrupt = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    settle(); check("int_en_low_wait", 32'(w_ctl), 32'(C_IDLE));
    int_en = 1'b1;
    settle(); check("int_en_rise_go", 32'(w_ctl), 32'(C_IDLE));
    expect_entry("late");

    // Exception in IDLE: EPC/CAUSE update and then hold, no spurious entry.
    exception_in = 1'b1; cause_in = 4'hF; exc_pc_in = 32'hDEAD_BEE0;
    settle(); check("exc_idle_outputs", 32'(w_ctl), 32'(C_EXC));
    tick();
    exception_in = 1'b0; cause_in = 4'h1; exc_pc_in = 32'h1111_1111;
    tick(); tick(); settle();
    check("exc_hold_epc",   EPC,        32'hDEAD_BEE0);
    check("exc_hold_cause", 32'(CAUSE), 32'hF);
    check("exc_hold_ctl",   32'(w_ctl), 32'(C_IDLE));

    // Interrupt held high for 20 cycles.
    clr_count = 0;
    interrupt = 1'b1;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (i == 19) interrupt = 1'b0;
      settle();
      if (clr_int) clr_count++;
    end
`ifdef PIPECTRL_INT_EDGE_EN
    check("held_entries", 32'(clr_count), 32'd1);
`else
    check("held_reentry", 32'(clr_count >= 2), 32'd1);
`endif
    reset = 1'b0;
    tick(); reset = 1'b1;
    tick(); settle(); check("final_idle", 32'(w_ctl), 32'(C_IDLE));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/pipeline_ctrl.md
Name: pipeline_ctrl

Overview:
- Central hazard and control-flow sequencer for the 5-stage pipeline (IF, ID, EX, MEM, WB).
- Produces stall/flush for the IF_ID, ID_EX and EX_MEM buffers and the PC source select for IF.
- Runs the multi-cycle interrupt entry: drain, push PC high, push PC low, push flags, vector.
- Latches EPC/CAUSE on exceptions.

Parameters:
- PC_W, 32, program-counter width
- REG_AW, 3, register-address width
- CAUSE_W, 4, exception-cause width
- DRAIN_CYCLES, 3, cycles waited for in-flight instructions to retire before the first push (1..15)

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  reset, synchronous, active-low (0 = reset)
- interrupt  in  1  external interrupt request
- int_en  in  1  INT flag from the flags register
- exception_in  in  1  exception raised in MEM, single-cycle pulse
- cause_in  in  CAUSE_W  exception number, valid with exception_in
- exc_pc_in  in  PC_W  PC of the faulting instruction
- jmp_taken  in  1  EX resolved a taken jump/call/ret
- idex_mem_read  in  1  instruction in ID_EX is a load
- idex_rdst  in  REG_AW  load destination
- ifid_rsrc, ifid_rdst  in  REG_AW  operands of the instruction in IF_ID
- ifid_use_src, ifid_use_dst  in  1  operand actually read
- push_ack  in  1  MEM accepted the current push
- int_pc  in  PC_W  return PC (next unexecuted instruction), sampled at DRAIN entry
- stall  out  1  hold PC and IF_ID
- flush_if_id, flush_id_ex, flush_ex_mem  out  1  insert bubble
- pc_sel  out  2  00 seq/jump, 01 int vector, 10 exception vector
- push_req  out  1  request one 16-bit push
- push_sel  out  2  00 PC[31:16], 01 PC[15:0], 10 flags
- push_pc  out  PC_W  latched return PC
- clr_int  out  1  one-cycle pulse clearing INT flag
- EPC  out  PC_W  exception PC
- CAUSE  out  CAUSE_W  exception cause

Behaviour:
- Reset (reset==0 at clk edge):
  - state=IDLE; pending, counters, EPC, CAUSE, push_pc cleared.
  - All outputs 0.
- FSM states: IDLE, DRAIN, PUSH_PCH, PUSH_PCL, PUSH_FLG, VECTOR.
- IDLE:
  - pending is set by interrupt.
  - If pending && int_en && !exception_in && !jmp_taken:
    - go to DRAIN; latch push_pc=int_pc; clear pending; pulse clr_int.
- DRAIN:
  - stall=1, flush_if_id=1.
  - Counter counts DRAIN_CYCLES cycles, then goes to PUSH_PCH.
- PUSH_PCH / PUSH_PCL / PUSH_FLG:
  - push_req=1, push_sel=00/01/10 respectively, stall=1.
  - Advance only on push_ack; hold indefinitely without it.
- VECTOR:
  - pc_sel=01, flush_if_id=1, for one cycle, then IDLE.
  - Total entry latency with push_ack tied high: DRAIN_CYCLES+4 cycles.
- Load-use hazard (IDLE only, combinational):
  - Condition: idex_mem_read && ((ifid_use_src && ifid_rsrc==idex_rdst) || (ifid_use_dst && ifid_rdst==idex_rdst)).
  - Response: stall=1, flush_id_ex=1.
- jmp_taken (IDLE): flush_if_id=flush_id_ex=1, stall=0. A jump overrides a load-use stall in the same cycle.
- exception_in, highest priority, any state:
  - EPC<=exc_pc_in, CAUSE<=cause_in.
  - All three flushes=1, pc_sel=10 for that cycle, state forced to IDLE.
  - An in-progress interrupt entry is abandoned and pending is re-set.
- EPC/CAUSE hold their values until the next exception or reset.
- interrupt while not IDLE: pending is set and serviced after return to IDLE.
- int_en=0: pending stays set and is serviced when int_en rises.
- reset mid-sequence: immediate IDLE; push_req drops on the next edge.

Optional Feature:
- Macro PIPECTRL_INT_EDGE_EN.
- Defined: pending is set only on a 0→1 transition of interrupt (registered previous value, cleared by reset); a held-high line yields one entry.
- Undefined: level-sensitive; pending is set every cycle interrupt==1, so a held line re-enters after each VECTOR once int_en is restored.

Decomposition:
- Shared package pipe_pkg holds:
  - state encoding (IDLE..VECTOR)
  - pc_sel codes PCSEL_SEQ/PCSEL_INT/PCSEL_EXC
  - push_sel codes PUSH_PCH/PUSH_PCL/PUSH_FLG
  - CAUSE_W and PC_W defaults
- One natural sub-module, hazard_detect: the combinational load-use comparator. The FSM stays in pipeline_ctrl.

Test Plan:
- Load-use: idex_mem_read=1, idex_rdst=3, ifid_rsrc=3, ifid_use_src=1 → stall=1, flush_id_ex=1 that cycle. Same with ifid_rsrc=4 → both 0.
- Jump vs stall: load-use condition and jmp_taken=1 together → stall=0, flush_if_id=flush_id_ex=1.
- Interrupt entry, DRAIN_CYCLES=3, push_ack=1, int_pc=0x0000_1234, int_en=1:
  - clr_int pulse at DRAIN entry.
  - push_sel 00,01,10 on cycles 4,5,6; push_pc=0x0000_1234.
  - pc_sel=01 on cycle 7; back to IDLE on cycle 8.
- Backpressure: push_ack=0 for 5 cycles in PUSH_PCL → push_sel stays 01 and stall stays 1; advances on the cycle after ack.
- Exception mid-entry: exception_in with cause_in=4'h2, exc_pc_in=0x0000_00A0 during PUSH_PCH → all flushes=1, pc_sel=10, EPC=0x0000_00A0, CAUSE=2, state IDLE, pending=1.
- Reset and edge mode:
  - reset=0 in DRAIN → all outputs 0 next cycle.
  - With PIPECTRL_INT_EDGE_EN, interrupt held high for 20 cycles → exactly one entry.
